neuron: RTL and testbench

Single trainable neuron that drives the activation unit's argument channel and consumes its feedback channel. It accepts a vector of N unsigned Q0.8 activations and computes a biased weighted sum with one multiply-accumulate per cycle. It then presents the saturated Q8.8 sum on `arg`. When training, it takes the returned Q8.8 delta on `fbk` and updates every weight plus the bias, one weight per cycle.

---
 rtl/neuron.sv | 142 ++++++++++++++
 tb/tb_neuron.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron.sv
// Single trainable neuron: Q0.8 inputs, Q8.8 weights and bias, one MAC per cycle
// forward pass, and a one-weight-per-cycle update from a Q8.8 feedback delta.
module neuron #(
  parameter int N          = 4,
  parameter int RATE_SHIFT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             train,
  input  logic             inp_valid,
  input  logic [8*N-1:0]   inp_data,
  output logic             inp_ready,
  output logic             arg_valid,
  output logic [15:0]      arg_data,
  input  logic             arg_ready,
  input  logic             fbk_valid,
  input  logic [15:0]      fbk_data,
  output logic             fbk_ready
);

  localparam int IW = $clog2(N + 1);

  localparam logic [2:0] S_INP = 3'd0;
  localparam logic [2:0] S_MAC = 3'd1;
  localparam logic [2:0] S_ARG = 3'd2;
  localparam logic [2:0] S_FBK = 3'd3;
  localparam logic [2:0] S_UPD = 3'd4;

  logic [2:0]          r_state;
  logic signed [15:0]  r_w [0:N];
  logic [7:0]          r_x [0:N-1];
  logic signed [31:0]  r_acc;
  logic [IW-1:0]       r_idx;
  logic signed [15:0]  r_delta;
  logic                r_arg_valid;
  logic [15:0]         r_arg_data;

  logic signed [15:0]  w_w_sel;
  logic [7:0]          w_x_sel;
  logic signed [24:0]  w_mac_prod;
  logic signed [31:0]  w_mac_sum;
  logic signed [9:0]   w_xi;
  logic signed [25:0]  w_upd_prod;
  logic signed [25:0]  w_upd_step;
  logic signed [26:0]  w_upd_sum;
  logic [15:0]         w_upd_new;

  function automatic logic [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)
      return 16'h7FFF;
    else if (v < -32'sd32768)
      return 16'h8000;
    else
      return v[15:0];
  endfunction

  // Index muxes; idx == N selects the bias weight and no input.
  always_comb begin
    w_w_sel = '0;
    w_x_sel = '0;
    for (int i = 0; i <= N; i++)
      if (r_idx == IW'(i)) w_w_sel = r_w[i];
    for (int i = 0; i < N; i++)
      if (r_idx == IW'(i)) w_x_sel = r_x[i];
  end

  assign w_mac_prod = 25'(w_w_sel) * 25'($signed({1'b0, w_x_sel}));
  assign w_mac_sum  = r_acc + 32'(w_mac_prod);

  assign w_xi       = (r_idx == IW'(N)) ? 10'sd256 : $signed({2'b00, w_x_sel});
  assign w_upd_prod = 26'(r_delta) * 26'(w_xi);
  assign w_upd_step = w_upd_prod >>> (8 + RATE_SHIFT);
  assign w_upd_sum  = 27'(w_w_sel) + 27'(w_upd_step);
  assign w_upd_new  = sat16(32'(w_upd_sum));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_INP;
      r_acc       <= '0;
      r_idx       <= '0;
      r_delta     <= '0;
      r_arg_valid <= 1'b0;
      r_arg_data  <= '0;
      for (int i = 0; i <= N; i++) r_w[i] <= '0;
      for (int i = 0; i < N; i++)  r_x[i] <= '0;
    end else begin
      case (r_state)
        S_INP: begin
          if (inp_valid) begin
            for (int i = 0; i < N; i++) r_x[i] <= inp_data[8*i +: 8];
            r_acc   <= 32'(r_w[N]) <<< 8;
            r_idx   <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_mac_sum;
          if (r_idx == IW'(N - 1)) begin
            r_idx   <= '0;
            r_state <= S_ARG;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_ARG: begin
          // First ARG cycle loads the output register; later cycles wait for the handshake.
          if (!r_arg_valid) begin
            r_arg_valid <= 1'b1;
            r_arg_data  <= sat16(r_acc >>> 8);
          end else if (arg_ready) begin
            r_arg_valid <= 1'b0;
            r_state     <= train ? S_FBK : S_INP;
          end
        end
        S_FBK: begin
          if (fbk_valid) begin
            r_delta <= $signed(fbk_data);
            r_idx   <= '0;
            r_state <= S_UPD;
          end
        end
        S_UPD: begin
          for (int i = 0; i <= N; i++)
            if (r_idx == IW'(i)) r_w[i] <= w_upd_new;
          if (r_idx == IW'(N)) begin
            r_idx   <= '0;
            r_state <= S_INP;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: r_state <= S_INP;
      endcase
    end
  end

  assign inp_ready = (r_state == S_INP);
  assign fbk_ready = (r_state == S_FBK);
  assign arg_valid = r_arg_valid;
  assign arg_data  = r_arg_data;

endmodule

// File: tb/tb_neuron.sv
// Directed bench for neuron: forward latency, training, saturation, backpressure, mid-update reset.
module tb_neuron;

  localparam int N  = 4;
  localparam int RS = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           train = 1'b0;
  logic           inp_valid = 1'b0;
  logic [8*N-1:0] inp_data = '0;
  logic           inp_ready;
  logic           arg_valid;
  logic [15:0]    arg_data;
  logic           arg_ready = 1'b0;
  logic           fbk_valid = 1'b0;
  logic [15:0]    fbk_data = '0;
  logic           fbk_ready;

  int checks = 0;
  int errors = 0;

  neuron #(.N(N), .RATE_SHIFT(RS)) dut (
    .clock     (clock),
    .reset     (reset),
    .train     (train),
    .inp_valid (inp_valid),
    .inp_data  (inp_data),
    .inp_ready (inp_ready),
    .arg_valid (arg_valid),
    .arg_data  (arg_data),
    .arg_ready (arg_ready),
    .fbk_valid (fbk_valid),
    .fbk_data  (fbk_data),
    .fbk_ready (fbk_ready)
  );

  always #5 clock = ~clock;

  // Stimulus helpers: all start and end just after a falling edge.
  task automatic send_inp(input logic [8*N-1:0] d);
    int t;
    t = 0;
    inp_data  = d;
    inp_valid = 1'b1;
    while (!inp_ready && t < 100) begin @(negedge clock); t++; end
    checks++;
    if (!inp_ready) begin
      errors++;
      $display("FAIL inp_accept: inp_ready=%b, required 1 within 100 cycles", inp_ready);
    end
    @(posedge clock);
    @(negedge clock);
    inp_valid = 1'b0;
    $display("inp   data=%h", d);
  endtask

  task automatic wait_arg(output int edges);
    edges = 0;
    while (!arg_valid && edges < 100) begin @(negedge clock); edges++; end
    checks++;
    if (!arg_valid) begin
      errors++;
      $display("FAIL arg_wait: arg_valid=%b, required 1 within 100 cycles", arg_valid);
    end
  endtask

  task automatic take_arg(input logic t, output logic [15:0] d);
    d         = arg_data;
    arg_ready = 1'b1;
    train     = t;
    @(posedge clock);
    @(negedge clock);
    arg_ready = 1'b0;
    train     = 1'b0;
    $display("arg   data=%h train=%b", d, t);
  endtask

  task automatic send_fbk(input logic [15:0] f);
    int t;
    t = 0;
    fbk_data  = f;
    fbk_valid = 1'b1;
    while (!fbk_ready && t < 100) begin @(negedge clock); t++; end
    checks++;
    if (!fbk_ready) begin
      errors++;
      $display("FAIL fbk_accept: fbk_ready=%b, required 1 within 100 cycles", fbk_ready);
    end
    @(posedge clock);
    @(negedge clock);
    fbk_valid = 1'b0;
    $display("fbk   data=%h", f);
  endtask

  task automatic wait_inp(output int edges);
    edges = 0;
    while (!inp_ready && edges < 100) begin @(negedge clock); edges++; end
  endtask

  task automatic forward(input logic [8*N-1:0] d, output logic [15:0] a, output int lat);
    send_inp(d);
    wait_arg(lat);
    take_arg(1'b0, a);
  endtask

  task automatic train_pass(input logic [8*N-1:0] d, input logic [15:0] f);
    int l;
    logic [15:0] a;
    send_inp(d);
    wait_arg(l);
    take_arg(1'b1, a);
    send_fbk(f);
    wait_inp(l);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (inp_ready !== 1'b1)  begin errors++; $display("FAIL reset_inp_ready: got %b, required 1", inp_ready); end
    checks++; if (arg_valid !== 1'b0)  begin errors++; $display("FAIL reset_arg_valid: got %b, required 0", arg_valid); end
    checks++; if (fbk_ready !== 1'b0)  begin errors++; $display("FAIL reset_fbk_ready: got %b, required 0", fbk_ready); end
    checks++; if (arg_data !== 16'h0)  begin errors++; $display("FAIL reset_arg_data: got %h, required 0000", arg_data); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (inp_ready !== 1'b1)  begin errors++; $display("FAIL post_reset_inp_ready: got %b, required 1", inp_ready); end
  endtask

  task automatic test_forward_zero();
    logic [15:0] a;
    int l;
    forward(32'h80808080, a, l);
    checks++; if (a !== 16'h0000) begin errors++; $display("FAIL fwd_zero_data: got %h, required 0000", a); end
    checks++; if (l != 5)         begin errors++; $display("FAIL fwd_latency: got %0d edges, required 5", l); end
    checks++; if (inp_ready !== 1'b1) begin errors++; $display("FAIL fwd_turnaround: inp_ready=%b, required 1", inp_ready); end
  endtask

  task automatic test_train();
    logic [15:0] a;
    logic [8*N-1:0] v;
    int l;
    send_inp(32'h80808080);
    wait_arg(l);
    take_arg(1'b1, a);
    checks++; if (fbk_ready !== 1'b1) begin errors++; $display("FAIL train_fbk_ready: got %b, required 1", fbk_ready); end
    checks++; if (inp_ready !== 1'b0) begin errors++; $display("FAIL train_inp_ready_low: got %b, required 0", inp_ready); end
    send_fbk(16'h0100);
    wait_inp(l);
    checks++; if (l != 5) begin errors++; $display("FAIL train_upd_len: got %0d edges, required 5", l); end
    // Weights 8, bias 16: 16 + 4*8*0.5 = 32
    forward(32'h80808080, a, l);
    checks++; if (a !== 16'h0020) begin errors++; $display("FAIL train_fwd_all: got %h, required 0020", a); end
    forward(32'h00000000, a, l);
    checks++; if (a !== 16'h0010) begin errors++; $display("FAIL train_fwd_bias: got %h, required 0010", a); end
    for (int i = 0; i < N; i++) begin
      v = 32'h80 << (8 * i);
      forward(v, a, l);
      checks++;
      if (a !== 16'h0014) begin errors++; $display("FAIL train_fwd_w%0d: got %h, required 0014", i, a); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a;
    int l;
    send_inp(32'h80808080);
    wait_arg(l);
    fbk_data  = 16'h0100;
    fbk_valid = 1'b1;
    inp_data  = 32'hFFFFFFFF;
    inp_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      train = k[0];
      @(negedge clock);
      checks++; if (arg_valid !== 1'b1)   begin errors++; $display("FAIL bp_valid_%0d: got %b, required 1", k, arg_valid); end
      checks++; if (arg_data !== 16'h0020) begin errors++; $display("FAIL bp_data_%0d: got %h, required 0020", k, arg_data); end
      checks++; if (fbk_ready !== 1'b0)   begin errors++; $display("FAIL bp_fbk_ready_%0d: got %b, required 0", k, fbk_ready); end
    end
    inp_valid = 1'b0;
    take_arg(1'b1, a);
    checks++; if (a !== 16'h0020)     begin errors++; $display("FAIL bp_arg: got %h, required 0020", a); end
    checks++; if (fbk_ready !== 1'b1) begin errors++; $display("FAIL bp_fbk_now_ready: got %b, required 1", fbk_ready); end
    @(posedge clock);
    @(negedge clock);
    fbk_valid = 1'b0;
    wait_inp(l);
    checks++; if (l != 5) begin errors++; $display("FAIL bp_upd_len: got %0d edges, required 5", l); end
    // Single update with x=0x80: weights 16, bias 32 -> 32 + 4*16*0.5 = 64
    forward(32'h80808080, a, l);
    checks++; if (a !== 16'h0040) begin errors++; $display("FAIL bp_fwd_after: got %h, required 0040", a); end
  endtask

  task automatic test_saturation();
    logic [15:0] a;
    logic [8*N-1:0] v;
    int l;
    pulse_reset();
    repeat (20) train_pass(32'hFFFFFFFF, 16'h7FFF);
    forward(32'h00000000, a, l);
    checks++; if (a !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_bias: got %h, required 7FFF", a); end
    forward(32'hFFFFFFFF, a, l);
    checks++; if (a !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_all: got %h, required 7FFF", a); end
    for (int i = 0; i < N; i++) begin
      v = 32'hFF << (8 * i);
      forward(v, a, l);
      checks++;
      if (a !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_w%0d: got %h, required 7FFF", i, a); end
    end
    pulse_reset();
    repeat (20) train_pass(32'hFFFFFFFF, 16'h8000);
    forward(32'h00000000, a, l);
    checks++; if (a !== 16'h8000) begin errors++; $display("FAIL sat_neg_bias: got %h, required 8000", a); end
    forward(32'hFFFFFFFF, a, l);
    checks++; if (a !== 16'h8000) begin errors++; $display("FAIL sat_neg_all: got %h, required 8000", a); end
    for (int i = 0; i < N; i++) begin
      v = 32'hFF << (8 * i);
      forward(v, a, l);
      checks++;
      if (a !== 16'h8000) begin errors++; $display("FAIL sat_neg_w%0d: got %h, required 8000", i, a); end
    end
  endtask

  task automatic test_reset_mid_upd();
    logic [15:0] a;
    int l;
    send_inp(32'h80808080);
    wait_arg(l);
    take_arg(1'b1, a);
    checks++; if (a !== 16'h8000) begin errors++; $display("FAIL mid_pre_arg: got %h, required 8000", a); end
    send_fbk(16'h0100);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    $display("reset asserted mid-update");
    checks++; if (inp_ready !== 1'b1) begin errors++; $display("FAIL mid_inp_ready: got %b, required 1", inp_ready); end
    checks++; if (arg_valid !== 1'b0) begin errors++; $display("FAIL mid_arg_valid: got %b, required 0", arg_valid); end
    checks++; if (fbk_ready !== 1'b0) begin errors++; $display("FAIL mid_fbk_ready: got %b, required 0", fbk_ready); end
    checks++; if (arg_data !== 16'h0) begin errors++; $display("FAIL mid_arg_data: got %h, required 0000", arg_data); end
    @(negedge clock);
    reset = 1'b1;
    send_inp(32'hFFFFFFFF);
    wait_arg(l);
    checks++; if (l != 5) begin errors++; $display("FAIL mid_first_edge_accept: got %0d edges, required 5", l); end
    take_arg(1'b0, a);
    checks++; if (a !== 16'h0000) begin errors++; $display("FAIL mid_weights_cleared: got %h, required 0000", a); end
  endtask

  initial begin
    test_reset();
    test_forward_zero();
    test_train();
    test_backpressure();
    test_saturation();
    test_reset_mid_upd();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
